// File: rtl/piso_register.sv
// piso_register: parallel-in / serial-out transmit register.
//
// A word is accepted over a valid/ready handshake and streamed onto Q one bit
// per enabled clock edge. first/last mark the frame boundaries. done pulses for
// one cycle after the final bit has been consumed. A reload is accepted on the
// last-bit cycle, so consecutive frames stream without a gap.
//
// Parameters:
//   WIDTH      word length in bits (2..32)
//   MSB_FIRST  1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
//
// Ports:
//   clock       in   single clock, rising-edge
//   reset       in   synchronous, active-high; overrides every other input
//   en          in   shift enable; a bit advances only on edges where en=1
//   load_valid  in   load_data is offered
//   load_data   in   word to serialize
//   load_ready  out  a word can be accepted this cycle (combinational)
//   Q           out  current serial bit
//   Q_valid     out  Q carries a frame bit
//   first       out  Q is the first bit of the frame
//   last        out  Q is the final bit of the frame
//   done        out  one-cycle pulse after the final bit is consumed
module piso_register #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             Q,
    output logic             Q_valid,
    output logic             first,
    output logic             last,
    output logic             done
);

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              q_q, q_d;
    logic              done_q, done_d;

    logic              is_shift;
    logic              last_bit;
    logic              do_load;

    always_comb begin
        is_shift   = (state_q == StShift);
        last_bit   = is_shift && (cnt_q == LastCnt);
        load_ready = !is_shift || (last_bit && en);
        do_load    = load_valid && load_ready;

        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = last_bit && en;

        if (do_load) begin
            shreg_d = load_data;
            cnt_d   = '0;
            state_d = StShift;
        end else if (is_shift && en) begin
            if (last_bit) begin
                state_d = StIdle;
            end else begin
                cnt_d = cnt_q + CntW'(1);
                // Shift toward the output end, zero-filling the vacated end.
                if (MSB_FIRST) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                end else begin
                    shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                end
            end
        end

        // Q is registered so it has no input-to-output path; in idle it keeps
        // the last bit driven.
        if (state_d == StShift) begin
            q_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
        end else begin
            q_d = q_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            done_q  <= done_d;
        end
    end

    assign Q       = q_q;
    assign Q_valid = is_shift;
    assign first   = is_shift && (cnt_q == '0);
    assign last    = last_bit;
    assign done    = done_q;

endmodule

// File: tb/tb_piso_register.sv
// Bench for piso_register: an MSB-first and an LSB-first instance share all
// inputs. A frame-level model (word + bit index) is compared against both on
// every falling edge; directed literal checks pin the model to known sequences.
module tb_piso_register;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         en;
    logic         load_valid;
    logic [W-1:0] load_data;

    logic rdy_m, q_m, qv_m, fst_m, lst_m, dn_m;
    logic rdy_l, q_l, qv_l, fst_l, lst_l, dn_l;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    piso_register #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (rdy_m),
        .Q          (q_m),
        .Q_valid    (qv_m),
        .first      (fst_m),
        .last       (lst_m),
        .done       (dn_m)
    );

    piso_register #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (rdy_l),
        .Q          (q_l),
        .Q_valid    (qv_l),
        .first      (fst_l),
        .last       (lst_l),
        .done       (dn_l)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // ---------------- frame-level model ----------------
    logic         m_busy;
    logic [W-1:0] m_word;
    int           m_idx;
    logic         m_q_msb, m_q_lsb, m_done;

    function automatic logic bit_at(input logic [W-1:0] w, input int idx, input bit msb);
        return msb ? w[W-1-idx] : w[idx];
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_busy  <= 1'b0;
            m_idx   <= 0;
            m_q_msb <= 1'b0;
            m_q_lsb <= 1'b0;
            m_done  <= 1'b0;
        end else begin
            m_done <= m_busy && en && (m_idx == W - 1);
            if (load_valid && (!m_busy || (m_idx == W - 1 && en))) begin
                m_word  <= load_data;
                m_idx   <= 0;
                m_busy  <= 1'b1;
                m_q_msb <= bit_at(load_data, 0, 1'b1);
                m_q_lsb <= bit_at(load_data, 0, 1'b0);
            end else if (m_busy && en) begin
                if (m_idx == W - 1) begin
                    m_busy <= 1'b0;
                end else begin
                    m_idx   <= m_idx + 1;
                    m_q_msb <= bit_at(m_word, m_idx + 1, 1'b1);
                    m_q_lsb <= bit_at(m_word, m_idx + 1, 1'b0);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            logic e_rdy, e_fst, e_lst;
            e_rdy = !m_busy || (m_idx == W - 1 && en);
            e_fst = m_busy && (m_idx == 0);
            e_lst = m_busy && (m_idx == W - 1);
            chk("msb.load_ready", rdy_m, e_rdy);
            chk("msb.Q",          q_m,   m_q_msb);
            chk("msb.Q_valid",    qv_m,  m_busy);
            chk("msb.first",      fst_m, e_fst);
            chk("msb.last",       lst_m, e_lst);
            chk("msb.done",       dn_m,  m_done);
            chk("lsb.load_ready", rdy_l, e_rdy);
            chk("lsb.Q",          q_l,   m_q_lsb);
            chk("lsb.Q_valid",    qv_l,  m_busy);
            chk("lsb.first",      fst_l, e_fst);
            chk("lsb.last",       lst_l, e_lst);
            chk("lsb.done",       dn_l,  m_done);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Load a word (en=1) and check the literal serial sequences on both DUTs.
    task automatic frame(input string name, input logic [W-1:0] data,
                         input logic [W-1:0] seq_m, input logic [W-1:0] seq_l);
        load_valid = 1'b1;
        load_data  = data;
        en         = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            chk({name, ".Q_msb"}, q_m, seq_m[W-1-i]);
            chk({name, ".Q_lsb"}, q_l, seq_l[W-1-i]);
            chk({name, ".first"}, fst_m, (i == 0));
            chk({name, ".last"},  lst_m, (i == W - 1));
            tick();
        end
        chk({name, ".done"},    dn_m, 1'b1);
        chk({name, ".Q_valid"}, qv_m, 1'b0);
    endtask

    initial begin
        int cycles;
        reset      = 1'b1;
        en         = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        tick();
        tick();
        reset  = 1'b0;
        chk_en = 1'b1;
        chk("reset.Q",          q_m,   1'b0);
        chk("reset.Q_valid",    qv_m,  1'b0);
        chk("reset.done",       dn_m,  1'b0);
        chk("reset.load_ready", rdy_m, 1'b1);

        // Basic frame; A5 reads the same in both orders.
        frame("a5", 8'hA5, 8'b10100101, 8'b10100101);
        tick();
        chk("idle.done", dn_m, 1'b0);

        // Bit order.
        frame("0f", 8'h0F, 8'b00001111, 8'b11110000);
        tick();

        // Stall for 3 cycles while bit 3 (value 0) is on Q.
        load_valid = 1'b1;
        load_data  = 8'hA5;
        en         = 1'b1;
        tick();
        load_valid = 1'b0;
        cycles     = 0;
        for (int i = 0; i < W; i++) begin
            chk("stall.Q", q_m, bit_at(8'hA5, i, 1'b1));
            if (i == 3) begin
                en = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    cycles++;
                    chk("stall.hold_Q",  q_m,   1'b0);
                    chk("stall.hold_qv", qv_m,  1'b1);
                    chk("stall.hold_fl", fst_m | lst_m, 1'b0);
                end
                en = 1'b1;
            end
            tick();
            cycles++;
        end
        chk("stall.len11", (cycles == 11), 1'b1);
        chk("stall.done",  dn_m, 1'b1);
        tick();

        // Back-to-back FF then 00.
        load_valid = 1'b1;
        load_data  = 8'hFF;
        chk("b2b.ready_idle", rdy_m, 1'b1);
        tick();
        load_data = 8'h00;
        for (int i = 0; i < W; i++) begin
            chk("b2b.ready", rdy_m, (i == W - 1));
            chk("b2b.Q1",    q_m,   1'b1);
            tick();
        end
        load_valid = 1'b0;
        chk("b2b.done9",  dn_m,  1'b1);
        chk("b2b.first9", fst_m, 1'b1);
        for (int i = 0; i < W; i++) begin
            chk("b2b.Q0", q_m,  1'b0);
            chk("b2b.qv", qv_m, 1'b1);
            tick();
        end
        tick();

        // Reset during bit 4 of A5.
        load_valid = 1'b1;
        load_data  = 8'hA5;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("rst.Q_bit4", q_m, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst.Q",       q_m | q_l, 1'b0);
        chk("rst.Q_valid", qv_m,  1'b0);
        chk("rst.flags",   fst_m | lst_m | dn_m, 1'b0);
        chk("rst.ready",   rdy_m, 1'b1);
        tick();
        chk("rst.no_done", dn_m, 1'b0);
        frame("3c", 8'h3C, 8'b00111100, 8'b00111100);
        tick();

        // Load offered during reset must be ignored.
        reset      = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'hFF;
        tick();
        reset      = 1'b0;
        load_valid = 1'b0;
        chk("rstload.Q_valid", qv_m, 1'b0);
        tick();
        chk("rstload.Q_valid2", qv_m, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
